// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment readback path: active-low segment
// patterns for hex digits 0-F and the capture FSM state type.
package seg7_pkg;

   // Active-low segment patterns, bit order g..a (bit6 = g, bit0 = a)
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      HOLD
   } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational active-low 7-segment pattern to hex nibble decoder; hit is
// low for any pattern that is not one of the sixteen hex glyphs.
module seg7_to_hex
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       hit
);

   always_comb begin
      nibble = 4'h0;
      hit    = 1'b1;
      case (seg)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: hit    = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Reads back a multiplexed active-low 7-segment bus and rebuilds the nibble per digit.
// Optional SEG7_CAPTURE_ERR_CNT_EN adds a saturating 8-bit err_count output.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   an_in,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    upd_valid,
   output logic                    upd_err,
   output logic [2:0]              upd_idx,
`ifdef SEG7_CAPTURE_ERR_CNT_EN
   output logic [7:0]              err_count,
`endif
   output logic                    frame_done
);

   localparam int CW = NUM_DIGITS + 7;
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
      int zeros;
      zeros = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an[i]) zeros++;
      end
      return (zeros == 1);
   endfunction

   function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] an);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   logic [6:0]            seg_p0, seg_p1;
   logic [NUM_DIGITS-1:0] an_p0, an_p1;
   logic [CW-1:0]         combo, combo_q;
   state_t                state, state_next;
   logic [7:0]            cnt, cnt_next;
   logic                  active, capture;
   logic [NUM_DIGITS-1:0] sel, seen, seen_base;
   logic                  seen_full;
   logic [2:0]            idx;
   logic [3:0]            nibble;
   logic                  hit;

   assign combo     = {an_p1, seg_p1};
   assign active    = one_low(an_p1);
   assign sel       = ~an_p1;
   assign idx       = low_index(an_p1);
   assign seen_full = &seen;
   assign seen_base = seen_full ? '0 : seen;

   seg7_to_hex u_dec (
      .seg    (seg_p1),
      .nibble (nibble),
      .hit    (hit)
   );

   // Stability tracking: counter restarts on any change of the single-digit combo
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      if (!active) begin
         state_next = IDLE;
         cnt_next   = 8'd0;
      end else if (state == IDLE || combo != combo_q) begin
         state_next = TRACK;
         cnt_next   = 8'd1;
      end else if (state == TRACK) begin
         cnt_next = cnt + 8'd1;
         if (cnt_next == STABLE) begin
            capture    = 1'b1;
            state_next = HOLD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_p0      <= SEG_BLANK;
         seg_p1      <= SEG_BLANK;
         an_p0       <= '1;
         an_p1       <= '1;
         combo_q     <= '1;
         state       <= IDLE;
         cnt         <= 8'd0;
         digits_out  <= '0;
         digit_valid <= '0;
         seen        <= '0;
         upd_valid   <= 1'b0;
         upd_err     <= 1'b0;
         upd_idx     <= 3'd0;
         frame_done  <= 1'b0;
      end else begin
         seg_p0     <= seg_in;
         seg_p1     <= seg_p0;
         an_p0      <= an_in;
         an_p1      <= an_p0;
         combo_q    <= combo;
         state      <= state_next;
         cnt        <= cnt_next;
         upd_valid  <= 1'b0;
         upd_err    <= 1'b0;
         frame_done <= seen_full && !clear;
         if (clear) begin
            digits_out  <= '0;
            digit_valid <= '0;
            seen        <= '0;
         end else begin
            seen <= seen_base;
            if (capture) begin
               upd_idx <= idx;
               if (hit) begin
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                     if (sel[i]) digits_out[4*i +: 4] <= nibble;
                  end
                  digit_valid <= digit_valid | sel;
                  seen        <= seen_base | sel;
                  upd_valid   <= 1'b1;
               end else begin
                  // Bad pattern keeps the old nibble but no longer vouches for it
                  digit_valid <= digit_valid & ~sel;
                  upd_err     <= 1'b1;
               end
            end
         end
      end
   end

`ifdef SEG7_CAPTURE_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         err_count <= 8'd0;
      end else if (capture && !hit && err_count != 8'hFF) begin
         err_count <= err_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: expected capture/frame events are queued
// with their due cycle when stimulus is applied and matched as pulses appear.
module tb_seg7_capture;
   import seg7_pkg::*;

   localparam int ND  = 4;
   localparam int SC  = 8;
   localparam int LAT = SC + 2;

   localparam int K_VALID = 0;
   localparam int K_ERR   = 1;
   localparam int K_FRAME = 2;

   logic            clk;
   logic            rst_n;
   logic [6:0]      seg_in;
   logic [ND-1:0]   an_in;
   logic            clear;
   logic [4*ND-1:0] digits_out;
   logic [ND-1:0]   digit_valid;
   logic            upd_valid;
   logic            upd_err;
   logic [2:0]      upd_idx;
   logic            frame_done;
`ifdef SEG7_CAPTURE_ERR_CNT_EN
   logic [7:0]      err_count;
`endif

   seg7_capture #(
      .NUM_DIGITS    (ND),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .an_in       (an_in),
      .clear       (clear),
      .digits_out  (digits_out),
      .digit_valid (digit_valid),
      .upd_valid   (upd_valid),
      .upd_err     (upd_err),
      .upd_idx     (upd_idx),
`ifdef SEG7_CAPTURE_ERR_CNT_EN
      .err_count   (err_count),
`endif
      .frame_done  (frame_done)
   );

   typedef struct {
      int kind;
      int idx;
      int cyc;
   } ev_t;

   ev_t sb[$];
   int  compared   = 0;
   int  mismatched = 0;
   int  cyc        = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int kind, input int idx, input int due);
      ev_t e;
      e.kind = kind;
      e.idx  = idx;
      e.cyc  = due;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [ND-1:0] a, input logic [6:0] s);
      an_in  = a;
      seg_in = s;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse monitor: every pulse must match the oldest queued expectation
   always @(negedge clk) begin
      ev_t e;
      if (upd_valid || upd_err) begin
         chk("upd_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("upd_kind", upd_err ? 32'd1 : 32'd0, 32'(e.kind));
            chk("upd_idx", 32'(upd_idx), 32'(e.idx));
            chk("upd_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (frame_done) begin
         chk("frame_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("frame_kind", 32'd2, 32'(e.kind));
            chk("frame_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   initial begin
      logic [6:0]    pats [4];
      logic [ND-1:0] a;
      int            t0;

      pats[0] = SEG_1;
      pats[1] = SEG_A;
      pats[2] = SEG_0;
      pats[3] = SEG_F;

      rst_n = 1'b0;
      clear = 1'b0;
      drive('1, SEG_BLANK);
      wait_cyc(3);
      chk("rst_digits", 32'(digits_out), 32'h0);
      chk("rst_valid", 32'(digit_valid), 32'h0);
      chk("rst_pulses", 32'({upd_valid, upd_err, frame_done}), 32'h0);
      chk("rst_idx", 32'(upd_idx), 32'h0);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      rst_n = 1'b1;

      // Steady digit 0 showing 3
      drive(4'b1110, SEG_3);
      push(K_VALID, 0, cyc + LAT);
      wait_cyc(20);
      chk("t1_digit0", 32'(digits_out[3:0]), 32'h3);
      chk("t1_valid", 32'(digit_valid), 32'b0001);

      // Pattern change mid-count restarts the stability window
      drive('1, SEG_BLANK);
      wait_cyc(4);
      drive(4'b1110, SEG_5);
      t0 = cyc;
      wait_cyc(5);
      drive(4'b1110, SEG_2);
      push(K_VALID, 0, t0 + 5 + LAT);
      wait_cyc(20);
      chk("t2_digit0", 32'(digits_out[3:0]), 32'h2);

      clear = 1'b1;
      wait_cyc(1);
      clear = 1'b0;
      chk("clr_digits", 32'(digits_out), 32'h0);
      chk("clr_valid", 32'(digit_valid), 32'h0);

      // Full scan 1,A,0,F
      for (int k = 0; k < 4; k++) begin
         a = ~(4'b0001 << k);
         drive(a, pats[k]);
         push(K_VALID, k, cyc + LAT);
         if (k == 3) push(K_FRAME, 0, cyc + LAT + 1);
         wait_cyc(12);
      end
      chk("scan_digits", 32'(digits_out), 32'hF0A1);
      chk("scan_valid", 32'(digit_valid), 32'b1111);

      // Blank on digit 1 is an error capture
      drive(4'b1101, SEG_BLANK);
      push(K_ERR, 1, cyc + LAT);
      wait_cyc(12);
      chk("err_valid", 32'(digit_valid), 32'b1101);
      chk("err_digits", 32'(digits_out), 32'hF0A1);
      chk("err_idx", 32'(upd_idx), 32'd1);

      // Two digits active never leaves IDLE
      drive(4'b1100, SEG_8);
      wait_cyc(30);
      chk("multi_state", 32'(dut.state), 32'(IDLE));
      chk("multi_cnt", 32'(dut.cnt), 32'd0);
      chk("multi_idx_hold", 32'(upd_idx), 32'd1);

      // Clear in the capture cycle swallows the capture; no re-capture while stable
      drive(4'b1011, SEG_8);
      wait_cyc(LAT - 1);
      clear = 1'b1;
      wait_cyc(1);
      clear = 1'b0;
      chk("clrcap_digits", 32'(digits_out), 32'h0);
      chk("clrcap_valid", 32'(digit_valid), 32'h0);
      wait_cyc(15);
      chk("clrcap_nocap", 32'(digit_valid), 32'h0);
      drive(4'b1011, SEG_7);
      push(K_VALID, 2, cyc + LAT);
      wait_cyc(12);
      chk("after_clr_digits", 32'(digits_out), 32'h0700);
      chk("after_clr_valid", 32'(digit_valid), 32'b0100);

      // Reset part-way through tracking abandons the count
      drive(4'b0111, SEG_9);
      t0 = cyc;
      wait_cyc(5);
      rst_n = 1'b0;
      wait_cyc(1);
      rst_n = 1'b1;
      chk("midrst_digits", 32'(digits_out), 32'h0);
      chk("midrst_idx", 32'(upd_idx), 32'h0);
      chk("midrst_cnt", 32'(dut.cnt), 32'h0);
      push(K_VALID, 3, t0 + 6 + LAT);
      wait_cyc(14);
      chk("midrst_recap", 32'(digits_out), 32'h9000);
      chk("midrst_valid", 32'(digit_valid), 32'b1000);

`ifdef SEG7_CAPTURE_ERR_CNT_EN
      chk("errcnt_start", 32'(err_count), 32'd0);
      for (int i = 0; i < 300; i++) begin
         drive(4'b1110, (i % 2 == 0) ? 7'b0111111 : SEG_BLANK);
         push(K_ERR, 0, cyc + LAT);
         wait_cyc(10);
      end
      wait_cyc(2);
      chk("errcnt_sat", 32'(err_count), 32'd255);
      clear = 1'b1;
      wait_cyc(1);
      clear = 1'b0;
      chk("errcnt_clear", 32'(err_count), 32'd0);
`endif

      wait_cyc(5);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
